// File: rtl/shift_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_tx_sequencer
// Brief    : Loads a parallel word into an external bidirectional shift
//            register and strobes it out WIDTH bits at DIVIDE clocks per bit.
// Revision : 1.0  initial release
// ============================================================================
module shift_tx_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIVIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] sr_parallel,
  output logic             sr_serial_in,
  output logic             sr_load,
  output logic             sr_lshift,
  output logic             sr_rshift,
  output logic             sr_en,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (DIVIDE > 1) ? $clog2(DIVIDE + 1) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIVIDE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      data_q  <= data_nxt;
      dir_q   <= dir_nxt;
      bit_cnt <= bit_nxt;
      div_cnt <= div_nxt;
    end
  end

  // Every output is a decode of registered state, so reset reaches them directly.
  always_comb begin
    state_nxt    = state;
    data_nxt     = data_q;
    dir_nxt      = dir_q;
    bit_nxt      = bit_cnt;
    div_nxt      = div_cnt;
    in_ready     = 1'b0;
    sr_parallel  = '0;
    sr_serial_in = 1'b0;
    sr_load      = 1'b0;
    sr_lshift    = 1'b0;
    sr_rshift    = 1'b0;
    sr_en        = 1'b0;
    bit_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_nxt  = in_data;
          dir_nxt   = in_msb_first;
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        sr_load     = 1'b1;
        sr_en       = 1'b1;
        sr_parallel = data_q;
        busy        = 1'b1;
        bit_nxt     = '0;
        div_nxt     = '0;
        state_nxt   = abort ? S_IDLE : S_SHIFT;
      end

      S_SHIFT: begin
        busy      = 1'b1;
        sr_lshift = dir_q;
        sr_rshift = ~dir_q;
        if (div_cnt == LAST_DIV) begin
          sr_en     = 1'b1;
          bit_valid = 1'b1;
          div_nxt   = '0;
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_DONE;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
        // A cancel still lets this cycle's strobe through; outputs drop next cycle.
        if (abort) begin
          state_nxt = S_IDLE;
          bit_nxt   = '0;
          div_nxt   = '0;
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        bit_nxt   = '0;
        div_nxt   = '0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_tx_sequencer.sv
`default_nettype none
// Testbench for shift_tx_sequencer: DIVIDE=1 and DIVIDE=3 instances, each
// driving a behavioural model of the attached bidirectional shift register.
module tb_shift_tx_sequencer;

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic [7:0] in_data      = 8'h00;
  logic       in_msb_first = 1'b0;
  logic       abort        = 1'b0;
  logic       a_valid      = 1'b0;
  logic       b_valid      = 1'b0;
  logic       sel          = 1'b0;

  logic       a_rdy, a_sin, a_load, a_ls, a_rs, a_en, a_bv, a_busy, a_done;
  logic       b_rdy, b_sin, b_load, b_ls, b_rs, b_en, b_bv, b_busy, b_done;
  logic [7:0] a_par, b_par;
  logic [7:0] a_q = 8'h00;
  logic [7:0] b_q = 8'h00;

  logic       rdy, sin, load, ls, rs, en, bv, busy, done, so;
  logic [7:0] par, sq;

  int vectors     = 0;
  int miscompares = 0;

  int         obs_wait, obs_load, obs_load_at, obs_shift, obs_strobe, obs_done;
  int         obs_done_at, obs_idle_at, obs_first_bv, obs_last_bv, obs_gap_min, obs_gap_max;
  logic [7:0] obs_par, obs_bits;
  bit         obs_dir_bad, obs_excl_bad, obs_sin_bad, obs_en_bad, obs_busy_bad, obs_timeout;

  always #5 clk = ~clk;

  shift_tx_sequencer #(.WIDTH(8), .DIVIDE(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_valid(a_valid), .in_ready(a_rdy), .abort(abort), .sr_parallel(a_par),
    .sr_serial_in(a_sin), .sr_load(a_load), .sr_lshift(a_ls), .sr_rshift(a_rs),
    .sr_en(a_en), .bit_valid(a_bv), .busy(a_busy), .done(a_done)
  );

  shift_tx_sequencer #(.WIDTH(8), .DIVIDE(3)) u_dut_div3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_valid(b_valid), .in_ready(b_rdy), .abort(abort), .sr_parallel(b_par),
    .sr_serial_in(b_sin), .sr_load(b_load), .sr_lshift(b_ls), .sr_rshift(b_rs),
    .sr_en(b_en), .bit_valid(b_bv), .busy(b_busy), .done(b_done)
  );

  // Attached 8-bit bidirectional shift registers.
  always @(posedge clk) begin
    if (a_en) begin
      if (a_load)    a_q <= a_par;
      else if (a_ls) a_q <= {a_q[6:0], a_sin};
      else if (a_rs) a_q <= {a_sin, a_q[7:1]};
    end
    if (b_en) begin
      if (b_load)    b_q <= b_par;
      else if (b_ls) b_q <= {b_q[6:0], b_sin};
      else if (b_rs) b_q <= {b_sin, b_q[7:1]};
    end
  end

  always_comb begin
    rdy  = sel ? b_rdy  : a_rdy;
    sin  = sel ? b_sin  : a_sin;
    load = sel ? b_load : a_load;
    ls   = sel ? b_ls   : a_ls;
    rs   = sel ? b_rs   : a_rs;
    en   = sel ? b_en   : a_en;
    bv   = sel ? b_bv   : a_bv;
    busy = sel ? b_busy : a_busy;
    done = sel ? b_done : a_done;
    par  = sel ? b_par  : a_par;
    sq   = sel ? b_q    : a_q;
    so   = ls ? sq[7] : (rs ? sq[0] : 1'b0);
  end

  // Offers one word and records what the selected instance does until it is idle again.
  task automatic send_word(input logic [7:0] d, input logic msb, input bit hold,
                           input logic [7:0] nxt, input int abort_at);
    int c;
    in_data = d; in_msb_first = msb;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    obs_wait = 0; obs_load = 0; obs_load_at = 0; obs_shift = 0; obs_strobe = 0;
    obs_done = 0; obs_done_at = 0; obs_idle_at = 0; obs_first_bv = 0; obs_last_bv = 0;
    obs_gap_min = 1000; obs_gap_max = 0; obs_par = 8'h00; obs_bits = 8'h00;
    obs_dir_bad = 0; obs_excl_bad = 0; obs_sin_bad = 0; obs_en_bad = 0;
    obs_busy_bad = 0; obs_timeout = 0;
    while (rdy !== 1'b1 && obs_wait < 100) begin
      @(posedge clk); #1; obs_wait++;
    end
    @(posedge clk); #1;
    if (!hold) begin a_valid = 1'b0; b_valid = 1'b0; end
    c = 1;
    while (rdy !== 1'b1 && c < 200) begin
      if (load === 1'b1) begin
        obs_load++; obs_par = par;
        if (obs_load_at == 0) obs_load_at = c;
      end
      if (ls === 1'b1 || rs === 1'b1) begin
        obs_shift++;
        if (ls !== msb || rs !== ~msb) obs_dir_bad = 1;
      end
      if ((load && (ls || rs)) || (ls && rs)) obs_excl_bad = 1;
      if (sin !== 1'b0) obs_sin_bad = 1;
      if (busy !== 1'b1) obs_busy_bad = 1;
      if (bv === 1'b1) begin
        obs_strobe++;
        obs_bits = {obs_bits[6:0], so};
        if (en !== 1'b1) obs_en_bad = 1;
        if (obs_first_bv == 0) obs_first_bv = c;
        else begin
          if (c - obs_last_bv < obs_gap_min) obs_gap_min = c - obs_last_bv;
          if (c - obs_last_bv > obs_gap_max) obs_gap_max = c - obs_last_bv;
        end
        obs_last_bv = c;
        if (abort_at != 0 && obs_strobe == abort_at) abort = 1'b1;
      end
      if (en === 1'b1 && load !== 1'b1 && bv !== 1'b1) obs_en_bad = 1;
      if (done === 1'b1) begin
        obs_done++; obs_done_at = c; in_data = nxt;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      c++;
    end
    obs_idle_at = c;
    if (rdy !== 1'b1) obs_timeout = 1;
  endtask

  task automatic test_reset;
    #1;
    vectors++; if ({a_rdy, b_rdy} !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b required 11", {a_rdy, b_rdy}); end
    vectors++; if ({a_busy, a_done, a_load, a_ls, a_rs, a_en, a_bv, a_par} !== 15'd0) begin miscompares++; $display("FAIL reset_outputs: got %h required 0", {a_busy, a_done, a_load, a_ls, a_rs, a_en, a_bv, a_par}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin miscompares++; $display("FAIL idle_ready cycle %0d: got %b%b required 11", i, a_rdy, b_rdy); end
      vectors++; if ({a_busy, a_done, a_load, a_ls, a_rs, a_en, a_bv, a_sin, a_par} !== 16'd0) begin miscompares++; $display("FAIL idle_outputs cycle %0d: got %h required 0", i, {a_busy, a_done, a_load, a_ls, a_rs, a_en, a_bv, a_sin, a_par}); end
      vectors++; if ({b_busy, b_done, b_load, b_ls, b_rs, b_en, b_bv} !== 7'd0) begin miscompares++; $display("FAIL idle_outputs_div3 cycle %0d: got %b required 0", i, {b_busy, b_done, b_load, b_ls, b_rs, b_en, b_bv}); end
    end
  endtask

  task automatic test_msb_div1;
    sel = 1'b0;
    send_word(8'hA5, 1'b1, 1'b0, 8'hA5, 0);
    vectors++; if (obs_timeout) begin miscompares++; $display("FAIL msb_timeout: got timeout required completion"); end
    vectors++; if (obs_load !== 1 || obs_load_at !== 1) begin miscompares++; $display("FAIL msb_load: got %0d loads at %0d required 1 at 1", obs_load, obs_load_at); end
    vectors++; if (obs_par !== 8'hA5) begin miscompares++; $display("FAIL msb_parallel: got %h required a5", obs_par); end
    vectors++; if (obs_shift !== 8 || obs_strobe !== 8) begin miscompares++; $display("FAIL msb_counts: got shift %0d strobe %0d required 8 8", obs_shift, obs_strobe); end
    vectors++; if (obs_first_bv !== 2 || obs_gap_min !== 1 || obs_gap_max !== 1) begin miscompares++; $display("FAIL msb_strobe_timing: got first %0d gaps %0d..%0d required 2 1..1", obs_first_bv, obs_gap_min, obs_gap_max); end
    vectors++; if (obs_bits !== 8'hA5) begin miscompares++; $display("FAIL msb_bits: got %h required a5", obs_bits); end
    vectors++; if (obs_done !== 1 || obs_done_at !== 10 || obs_idle_at !== 11) begin miscompares++; $display("FAIL msb_latency: got done %0dx at %0d ready at %0d required 1x at 10 ready at 11", obs_done, obs_done_at, obs_idle_at); end
    vectors++; if (obs_dir_bad || obs_excl_bad || obs_sin_bad || obs_en_bad || obs_busy_bad) begin miscompares++; $display("FAIL msb_controls: got dir %0d excl %0d sin %0d en %0d busy %0d required all 0", obs_dir_bad, obs_excl_bad, obs_sin_bad, obs_en_bad, obs_busy_bad); end
    vectors++; if (a_q !== 8'h00) begin miscompares++; $display("FAIL msb_final_reg: got %h required 00", a_q); end
  endtask

  task automatic test_lsb_div3;
    sel = 1'b1;
    send_word(8'h81, 1'b0, 1'b0, 8'h81, 0);
    vectors++; if (obs_timeout) begin miscompares++; $display("FAIL lsb_timeout: got timeout required completion"); end
    vectors++; if (obs_par !== 8'h81 || obs_load_at !== 1) begin miscompares++; $display("FAIL lsb_load: got %h at %0d required 81 at 1", obs_par, obs_load_at); end
    vectors++; if (obs_shift !== 24 || obs_strobe !== 8) begin miscompares++; $display("FAIL lsb_counts: got shift %0d strobe %0d required 24 8", obs_shift, obs_strobe); end
    vectors++; if (obs_first_bv !== 4 || obs_gap_min !== 3 || obs_gap_max !== 3) begin miscompares++; $display("FAIL lsb_strobe_timing: got first %0d gaps %0d..%0d required 4 3..3", obs_first_bv, obs_gap_min, obs_gap_max); end
    vectors++; if (obs_bits !== 8'h81) begin miscompares++; $display("FAIL lsb_bits: got %h required 81", obs_bits); end
    vectors++; if (obs_done !== 1 || obs_done_at !== 26 || obs_idle_at !== 27) begin miscompares++; $display("FAIL lsb_latency: got done %0dx at %0d ready at %0d required 1x at 26 ready at 27", obs_done, obs_done_at, obs_idle_at); end
    vectors++; if (obs_dir_bad || obs_excl_bad || obs_en_bad) begin miscompares++; $display("FAIL lsb_controls: got dir %0d excl %0d en %0d required 0", obs_dir_bad, obs_excl_bad, obs_en_bad); end
    vectors++; if (b_q !== 8'h00) begin miscompares++; $display("FAIL lsb_final_reg: got %h required 00", b_q); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    send_word(8'h3C, 1'b1, 1'b1, 8'hC3, 0);
    vectors++; if (obs_bits !== 8'h3C || obs_done !== 1) begin miscompares++; $display("FAIL b2b_first: got bits %h done %0d required 3c 1", obs_bits, obs_done); end
    vectors++; if (obs_idle_at !== 11 || obs_load !== 1) begin miscompares++; $display("FAIL b2b_first_ready: got ready at %0d loads %0d required 11 1", obs_idle_at, obs_load); end
    send_word(8'hC3, 1'b1, 1'b0, 8'hC3, 0);
    vectors++; if (obs_wait !== 0 || obs_load_at !== 1) begin miscompares++; $display("FAIL b2b_accept: got wait %0d load at %0d required 0 1", obs_wait, obs_load_at); end
    vectors++; if (obs_bits !== 8'hC3 || obs_par !== 8'hC3) begin miscompares++; $display("FAIL b2b_second: got bits %h par %h required c3 c3", obs_bits, obs_par); end
  endtask

  task automatic test_abort;
    sel = 1'b0;
    send_word(8'hFF, 1'b1, 1'b0, 8'hFF, 4);
    vectors++; if (obs_strobe !== 4 || obs_done !== 0) begin miscompares++; $display("FAIL abort_stop: got strobes %0d done %0d required 4 0", obs_strobe, obs_done); end
    vectors++; if (obs_idle_at !== 6 || a_rdy !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got ready at %0d rdy %b required 6 1", obs_idle_at, a_rdy); end
    vectors++; if (a_q !== 8'hF0) begin miscompares++; $display("FAIL abort_partial: got %h required f0", a_q); end
    send_word(8'h0F, 1'b1, 1'b0, 8'h0F, 0);
    vectors++; if (obs_bits !== 8'h0F || obs_done !== 1 || obs_done_at !== 10) begin miscompares++; $display("FAIL abort_recover: got bits %h done %0d at %0d required 0f 1 at 10", obs_bits, obs_done, obs_done_at); end
  endtask

  task automatic test_async_reset;
    int strobes;
    int n;
    sel = 1'b0;
    strobes = 0; n = 0;
    in_data = 8'h96; in_msb_first = 1'b1; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    while (strobes < 5 && n < 40) begin
      if (a_bv === 1'b1) strobes++;
      if (strobes < 5) begin @(posedge clk); #1; n++; end
    end
    vectors++; if (strobes !== 5) begin miscompares++; $display("FAIL arst_reach_bit5: got %0d strobes required 5", strobes); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (a_rdy !== 1'b1 || a_busy !== 1'b0) begin miscompares++; $display("FAIL arst_immediate: got rdy %b busy %b required 1 0", a_rdy, a_busy); end
    vectors++; if ({a_load, a_ls, a_rs, a_en, a_bv, a_done, a_par} !== 14'd0) begin miscompares++; $display("FAIL arst_outputs: got %h required 0", {a_load, a_ls, a_rs, a_en, a_bv, a_done, a_par}); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (a_q !== 8'h60) begin miscompares++; $display("FAIL arst_partial: got %h required 60", a_q); end
    @(negedge clk); rst = 1'b1;
    send_word(8'h55, 1'b0, 1'b0, 8'h55, 0);
    vectors++; if (obs_bits !== 8'hAA || obs_done !== 1 || obs_par !== 8'h55) begin miscompares++; $display("FAIL arst_recover: got bits %h done %0d par %h required aa 1 55", obs_bits, obs_done, obs_par); end
    vectors++; if (a_q !== 8'h00 || obs_dir_bad) begin miscompares++; $display("FAIL arst_recover_reg: got %h dir %0d required 00 0", a_q, obs_dir_bad); end
  endtask

  initial begin
    test_reset();
    test_msb_div1();
    test_lsb_div3();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/shift_tx_sequencer.md
Name: shift_tx_sequencer

Overview:
- Control sequencer that sits directly upstream of the 8-bit bidirectional shift register and drives its load/lshift/rshift/en/parallelIn/serialIn inputs.
- Accepts a parallel word over a valid/ready handshake, loads it into the shift register, then issues exactly WIDTH shift strobes at a programmable bit rate, MSB-first or LSB-first.
- Tells the downstream serial consumer when the register's serialOut bit is valid.

Parameters:
- WIDTH, 8, word length in bits; must equal the attached shift register width.
- DIVIDE, 1, clock cycles per serial bit; legal range is DIVIDE >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  word to transmit
- in_msb_first  input  1  direction select, captured with in_data: 1 = left shift (MSB first), 0 = right shift (LSB first)
- in_valid  input  1  in_data/in_msb_first valid
- in_ready  output  1  sequencer can accept a word
- abort  input  1  synchronous cancel of the current transfer
- sr_parallel  output  WIDTH  drives shift register parallelIn
- sr_serial_in  output  1  drives shift register serialIn; constant 0 (zero fill)
- sr_load  output  1  drives shift register load
- sr_lshift  output  1  drives shift register lshift
- sr_rshift  output  1  drives shift register rshift
- sr_en  output  1  drives shift register en
- bit_valid  output  1  shift register serialOut holds a valid data bit this cycle; consumer samples on this cycle's rising edge
- busy  output  1  transfer in progress (LOAD, SHIFT or DONE state)
- done  output  1  one-cycle pulse after the last bit

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Internal registers: data_q (WIDTH), dir_q, bit_cnt (clog2(WIDTH+1)), div_cnt (clog2(DIVIDE+1)).
- Reset (rst=0, asynchronous): state=IDLE, data_q=0, dir_q=0, counters=0. All outputs 0 except in_ready=1.
- IDLE:
  - in_ready=1; all sr_* outputs 0; busy=0.
  - If in_valid=1, capture in_data→data_q and in_msb_first→dir_q, then go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: sr_load=1, sr_en=1, sr_parallel=data_q, lshift=rshift=0, busy=1, in_ready=0.
  - Next state SHIFT; bit_cnt=0, div_cnt=0.
- SHIFT:
  - Held for the whole state: sr_lshift=dir_q, sr_rshift=~dir_q, so serialOut is valid throughout SHIFT.
  - div_cnt increments each cycle.
  - On the cycle where div_cnt==DIVIDE-1: sr_en=1, bit_valid=1, div_cnt→0, bit_cnt+1.
  - When bit_cnt reaches WIDTH-1 and that strobe fires, go to DONE.
  - SHIFT lasts exactly WIDTH*DIVIDE cycles and produces exactly WIDTH sr_en strobes.
- DONE (exactly 1 cycle): done=1, busy=1, all sr_* outputs 0, then IDLE.
- Latency with DIVIDE=1: handshake at cycle T, LOAD at T+1, shift strobes at T+2..T+1+WIDTH, done at T+2+WIDTH, in_ready=1 again at T+3+WIDTH.
- Handshake timing: in_ready is a registered state decode. A word offered while busy is not accepted; in_valid may stay high and is taken on the first IDLE cycle.
- abort=1 in LOAD or SHIFT: next state IDLE, no done pulse, sr_* outputs 0 from the next cycle. The shift register keeps its partial contents. abort is ignored in IDLE and DONE.
- sr_load, sr_lshift and sr_rshift are never high together. sr_lshift and sr_rshift are mutually exclusive in every state.
- Bit order delivered on serialOut at the bit_valid cycles: MSB-first gives data[WIDTH-1]..data[0]; LSB-first gives data[0]..data[WIDTH-1].
- Reset asserted mid-transfer: immediate return to the reset values, no done pulse.

Test Plan:
- Reset then idle: hold rst=0, release, in_valid=0 for 10 cycles -> in_ready=1, busy=0, all sr_*=0, done never pulses.
- MSB-first, DIVIDE=1: 8'hA5 with in_msb_first=1 -> 1 LOAD cycle with sr_parallel=8'hA5, then 8 cycles of sr_lshift=1 and sr_en=1; serialOut at the bit_valid cycles reads 1,0,1,0,0,1,0,1; done 1 cycle later; register ends at 8'h00.
- LSB-first, DIVIDE=3: 8'h81 with in_msb_first=0 -> 24 SHIFT cycles with sr_rshift=1; sr_en and bit_valid pulse every 3rd cycle (8 pulses); bits read 1,0,0,0,0,0,0,1.
- Back-to-back handshake: in_valid held high with 8'h3C then 8'hC3 -> second word accepted on the first IDLE cycle after done; in_ready low throughout the first transfer; both words serialized correctly in order.
- Abort: abort=1 on the 4th SHIFT strobe of 8'hFF -> IDLE next cycle, no done pulse, in_ready=1; a new word 8'h0F then transfers normally.
- Async reset mid-SHIFT: drop rst during the 5th bit -> outputs reach their reset values without waiting for a clock edge; after release, a normal transfer of 8'h55 succeeds.
